// File: rtl/pkg_batalha.sv
// Shared definitions for the battleship attack-register slice: board geometry,
// 2-bit status codes driven to the 7-segment path, FSM state encoding and the
// (row, column) -> matrix bit index mapping used by every 35-bit matrix.
package pkg_batalha;

  localparam int N_LIN   = 5;
  localparam int N_COL   = 7;
  localparam int N_CELLS = 35;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_AGUA   = 2'b01,
    ST_ACERTO = 2'b10,
    ST_INVAL  = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_DEB_PRESS = 2'b01,
    S_CHECK     = 2'b10,
    S_DEB_REL   = 2'b11
  } state_t;

  // Column-major with row 0 at the top of each 5-bit column group.
  function automatic logic [5:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
    return ({3'b000, col} * 6'd5) + (6'd4 - {3'b000, row});
  endfunction

endpackage

// File: rtl/modulo_debounce_botao.sv
// Two-flop synchroniser plus debounce counter for one raw push button.
// o_sync is the synchronised level; o_stable only changes after DEB_CYCLES
// consecutive synchronised samples that differ from the current stable level.
module modulo_debounce_botao #(
  parameter int DEB_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_sync,
  output logic o_stable
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // Synchronise, then count consecutive samples at the opposite level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (r_s2 != r_stable) begin
        if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          r_stable <= r_s2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_sync   = r_s2;
  assign o_stable = r_stable;

endmodule

// File: rtl/modulo_registro_ataque.sv
// Attack-matrix write side: debounces the confirm/clear buttons, classifies a
// confirmed coordinate as miss / hit / invalid-or-repeated against the ship
// matrix, and updates the shot and hit matrices plus the 7-seg status code.
// Optional shot budget: define SHOT_LIMIT_EN to end the game after MAX_SHOTS
// valid shots.
//
// Handshake: there is no valid/ready pair; one debounced confirm press is the
// request and busy is high from the first synchronised high sample until the
// release has been debounced, so exactly one CHECK happens per press.
module modulo_registro_ataque
  import pkg_batalha::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int MAX_SHOTS  = 20
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               button_confirmation,
  input  logic               button_clear,
  input  logic [5:0]         coord_at,
  input  logic [N_CELLS-1:0] m_po,
  output logic [N_CELLS-1:0] m_at,
  output logic [N_CELLS-1:0] m_tiro,
  output logic [1:0]         status,
  output logic               game_over,
  output logic               busy
);

  state_t             r_state;
  status_t            r_status;
  logic [N_CELLS-1:0] r_m_at;
  logic [N_CELLS-1:0] r_m_tiro;
  logic               r_game_over;
  logic               r_clr_stable_d;

  logic       w_conf_sync;
  logic       w_conf_stable;
  logic       w_clr_sync_unused;
  logic       w_clr_stable;
  logic       w_clr_pulse;
  logic [2:0] w_row;
  logic [2:0] w_col;
  logic       w_in_range;
  logic [5:0] w_idx;
  logic       w_shot_ok;
  logic       w_limit;
  logic       w_go_next;

  modulo_debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb_conf (
    .i_clk    (clk),
    .i_rst_n  (clr),
    .i_btn    (button_confirmation),
    .o_sync   (w_conf_sync),
    .o_stable (w_conf_stable)
  );

  modulo_debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .i_clk    (clk),
    .i_rst_n  (clr),
    .i_btn    (button_clear),
    .o_sync   (w_clr_sync_unused),
    .o_stable (w_clr_stable)
  );

  assign w_row      = coord_at[5:3];
  assign w_col      = coord_at[2:0];
  assign w_in_range = (w_row < 3'(N_LIN)) && (w_col < 3'(N_COL));
  assign w_idx      = cell_idx(w_row, w_col);
  // A shot writes only when the game is live, the cell exists and is fresh.
  assign w_shot_ok  = !r_game_over && !w_limit && w_in_range && !r_m_tiro[w_idx];
  assign w_go_next  = ((m_po != '0) && ((r_m_at & m_po) == m_po)) || w_limit;
  assign w_clr_pulse = w_clr_stable && !r_clr_stable_d;

`ifdef SHOT_LIMIT_EN
  localparam int SW = $clog2(MAX_SHOTS + 1);
  logic [SW-1:0] r_shots;

  assign w_limit = (r_shots >= SW'(MAX_SHOTS));

  // Count every valid, non-repeated shot; clear restarts the budget.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_shots <= '0;
    end else if (w_clr_pulse) begin
      r_shots <= '0;
    end else if ((r_state == S_CHECK) && w_shot_ok) begin
      r_shots <= r_shots + 1'b1;
    end
  end
`else
  logic w_unused_cfg;
  assign w_limit      = 1'b0;
  assign w_unused_cfg = (MAX_SHOTS == 0);
`endif

  // Edge-detect the debounced clear level so one press clears once.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_clr_stable_d <= 1'b0;
    end else begin
      r_clr_stable_d <= w_clr_stable;
    end
  end

  // Press/check/release FSM with registered matrices, status and game_over.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= S_IDLE;
      r_status    <= ST_IDLE;
      r_m_at      <= '0;
      r_m_tiro    <= '0;
      r_game_over <= 1'b0;
    end else if (w_clr_pulse) begin
      r_status    <= ST_IDLE;
      r_m_at      <= '0;
      r_m_tiro    <= '0;
      r_game_over <= 1'b0;
      // A press in flight (or still held) must be released before the next one.
      if (r_state == S_IDLE) begin
        r_state <= S_IDLE;
      end else begin
        r_state <= S_DEB_REL;
      end
    end else begin
      r_game_over <= w_go_next;
      case (r_state)
        S_IDLE: begin
          if (w_conf_sync) begin
            r_state <= S_DEB_PRESS;
          end
        end
        S_DEB_PRESS: begin
          if (w_conf_stable) begin
            r_state <= S_CHECK;
          end else if (!w_conf_sync) begin
            r_state <= S_IDLE;
          end
        end
        S_CHECK: begin
          r_state <= S_DEB_REL;
          if (!w_shot_ok) begin
            r_status <= ST_INVAL;
          end else begin
            r_m_tiro[w_idx] <= 1'b1;
            if (m_po[w_idx]) begin
              r_m_at[w_idx] <= 1'b1;
              r_status      <= ST_ACERTO;
            end else begin
              r_status <= ST_AGUA;
            end
          end
        end
        S_DEB_REL: begin
          if (!w_conf_stable) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_at      = r_m_at;
  assign m_tiro    = r_m_tiro;
  assign status    = r_status;
  assign game_over = r_game_over;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_modulo_registro_ataque.sv
// Bench for modulo_registro_ataque with DEB_CYCLES=4: directed scenarios plus a
// randomized shot sequence, all checked against a board-level model (shot/hit
// grids indexed by row and column).
module tb_modulo_registro_ataque;

  localparam int DEB  = 4;
  localparam int MAXS = 2;

  logic        clk;
  logic        clr;
  logic        bconf;
  logic        bclr;
  logic [5:0]  coord;
  logic [34:0] m_po;
  logic [34:0] m_at;
  logic [34:0] m_tiro;
  logic [1:0]  status;
  logic        game_over;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Board model
  bit         mshot[5][7];
  bit         mhit[5][7];
  logic [1:0] mstat;
  int         mshots;

  modulo_registro_ataque #(.DEB_CYCLES(DEB), .MAX_SHOTS(MAXS)) dut (
    .clk                 (clk),
    .clr                 (clr),
    .button_confirmation (bconf),
    .button_clear        (bclr),
    .coord_at            (coord),
    .m_po                (m_po),
    .m_at                (m_at),
    .m_tiro              (m_tiro),
    .status              (status),
    .game_over           (game_over),
    .busy                (busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ship_at(input int r, input int c);
    return m_po[c*5 + 4 - r];
  endfunction

  function automatic logic [34:0] grid_vec(input bit want_hit);
    logic [34:0] v;
    v = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 7; c++)
        v[c*5 + 4 - r] = want_hit ? mhit[r][c] : mshot[r][c];
    return v;
  endfunction

  function automatic bit model_go();
    bit any_ship;
    bit all_hit;
    any_ship = 1'b0;
    all_hit  = 1'b1;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 7; c++)
        if (ship_at(r, c)) begin
          any_ship = 1'b1;
          if (!mhit[r][c]) all_hit = 1'b0;
        end
`ifdef SHOT_LIMIT_EN
    if (mshots >= MAXS) return 1'b1;
`endif
    return any_ship && all_hit;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 7; c++) begin
        mshot[r][c] = 1'b0;
        mhit[r][c]  = 1'b0;
      end
    mstat  = 2'b00;
    mshots = 0;
  endtask

  task automatic model_shot(input logic [5:0] c6);
    int r;
    int c;
    r = int'(c6[5:3]);
    c = int'(c6[2:0]);
    if (model_go() || r > 4 || c > 6) begin
      mstat = 2'b11;
    end else if (mshot[r][c]) begin
      mstat = 2'b11;
    end else begin
      mshot[r][c] = 1'b1;
      mshots++;
      if (ship_at(r, c)) begin
        mhit[r][c] = 1'b1;
        mstat      = 2'b10;
      end else begin
        mstat = 2'b01;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":status"}, 35'(status), 35'(mstat));
    check({tag, ":m_at"}, m_at, grid_vec(1'b1));
    check({tag, ":m_tiro"}, m_tiro, grid_vec(1'b0));
    check({tag, ":game_over"}, 35'(game_over), 35'(model_go()));
    check({tag, ":busy"}, 35'(busy), 35'(0));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":idle_timeout"}, 35'(busy), 35'(0));
    repeat (DEB + 4) @(negedge clk);
  endtask

  // One confirmed press, with exact-latency checks around edge DEB+3.
  task automatic do_shot(input logic [5:0] c6, input int hold, input string tag);
    logic [1:0] pre_s;
    logic [1:0] post_s;
    bit         pre_go;
    bit         post_go;
    @(negedge clk);
    coord = c6;
    bconf = 1'b1;
    pre_s  = mstat;
    pre_go = model_go();
    model_shot(c6);
    post_s  = mstat;
    post_go = model_go();
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      if (k == DEB + 2) begin
        check({tag, ":status_before"}, 35'(status), 35'(pre_s));
      end
      if (k == DEB + 3) begin
        check({tag, ":status_at_edge"}, 35'(status), 35'(post_s));
        check({tag, ":go_at_edge"}, 35'(game_over), 35'(pre_go));
      end
      if (k == DEB + 4) begin
        check({tag, ":go_next_edge"}, 35'(game_over), 35'(post_go));
      end
    end
    @(negedge clk);
    bconf = 1'b0;
    wait_idle(tag);
    check_all(tag);
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    bclr = 1'b1;
    repeat (DEB + 4) @(negedge clk);
    bclr = 1'b0;
    repeat (DEB + 4) @(negedge clk);
    model_reset();
    check_all(tag);
  endtask

  initial begin
    int idx;
    int r;
    int c;
    logic [5:0] rc;

    // Reset
    clr   = 1'b0;
    bconf = 1'b0;
    bclr  = 1'b0;
    coord = '0;
    m_po  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    clr = 1'b1;
    repeat (2) @(negedge clk);

    // Hit on row 0 col 6 (index 34)
    m_po     = '0;
    m_po[34] = 1'b1;
    repeat (2) @(negedge clk);
    do_shot(6'b000_110, 10, "hit34");
    do_shot(6'b000_110, 10, "repeat34");
    do_shot(6'b001_000, 10, "miss3");

    // Glitch shorter than the debounce window
    @(negedge clk);
    coord = 6'b010_010;
    bconf = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch:busy_high", 35'(busy), 35'(1));
    bconf = 1'b0;
    wait_idle("glitch");
    check_all("glitch");

    // Out-of-board coordinates
    do_shot(6'b101_000, 10, "row5");
    do_shot(6'b000_111, 10, "col7");

    // Two ships, sink both, then clear
    do_clear("clear1");
    m_po     = '0;
    m_po[17] = 1'b1;
    m_po[30] = 1'b1;
    repeat (2) @(negedge clk);
    do_shot(6'b010_011, 10, "ship_a");
    do_shot(6'b100_110, 10, "ship_b");
    check("two_ships:game_over", 35'(game_over), 35'(1));
    do_shot(6'b000_000, 10, "after_go");
    do_clear("clear2");

`ifdef SHOT_LIMIT_EN
    // Shot budget
    m_po    = '0;
    m_po[4] = 1'b1;
    repeat (2) @(negedge clk);
    do_shot(6'b001_001, 10, "lim_miss1");
    do_shot(6'b010_001, 10, "lim_miss2");
    check("limit:game_over", 35'(game_over), 35'(1));
    do_shot(6'b000_000, 10, "lim_third");
    do_clear("clear_lim");
`endif

    // Randomized shots against a random fleet
    m_po = '0;
    repeat (5) m_po[$urandom_range(0, 34)] = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 24; s++) begin
      if ($urandom_range(0, 1) == 1) begin
        do begin
          idx = int'($urandom_range(0, 34));
        end while (!m_po[idx]);
        c  = idx / 5;
        r  = 4 - (idx % 5);
        rc = {3'(r), 3'(c)};
      end else if ($urandom_range(0, 3) == 0) begin
        rc = 6'($urandom_range(0, 63));
      end else begin
        rc = {3'($urandom_range(0, 4)), 3'($urandom_range(0, 6))};
      end
      do_shot(rc, int'($urandom_range(9, 13)), $sformatf("rand%0d", s));
    end

    // Reset asserted during press debounce
    do_clear("clear3");
    m_po    = '0;
    m_po[0] = 1'b1;
    repeat (2) @(negedge clk);
    do_shot(6'b001_010, 10, "pre_clr");
    @(negedge clk);
    coord = 6'b100_000;
    bconf = 1'b1;
    repeat (4) @(negedge clk);
    clr = 1'b0;
    #1;
    model_reset();
    check("clr_mid:busy", 35'(busy), 35'(0));
    check("clr_mid:m_tiro", m_tiro, 35'(0));
    @(negedge clk);
    bconf = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (DEB + 8) @(negedge clk);
    check_all("clr_mid_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/modulo_registro_ataque.md
Name: modulo_registro_ataque

Overview:
- Write side of the attack matrix that the display scanning logic reads.
- Takes a confirmed attack coordinate and looks it up in the ship-position matrix.
- Classifies the shot as miss, hit or invalid/repeated, then sets the matching bits in the shot and hit matrices and updates the 2-bit status driven to the 7-seg path.
- Includes press synchronisation and debounce for the confirmation and clear buttons, so one physical press produces exactly one write.

Parameters:
- DEB_CYCLES, 16: consecutive stable synchronised samples required to accept a button press or release.
- MAX_SHOTS, 20: shot budget; used only when SHOT_LIMIT_EN is defined.

Ports:
- clk  input  1  system clock
- clr  input  1  reset, asynchronous, active-low
- button_confirmation  input  1  raw confirm button, active-high, asynchronous to clk
- button_clear  input  1  raw game-clear button, active-high, asynchronous to clk
- coord_at  input  6  [5:3] row 0..4, [2:0] column 0..6; sampled in CHECK
- m_po  input  35  ship positions, 1 = ship; bit index = col*5 + (4-row)
- m_at  output  35  hit matrix, same indexing as m_po
- m_tiro  output  35  shot-fired matrix, same indexing
- status  output  2  00 idle, 01 miss, 10 hit, 11 invalid/repeated
- game_over  output  1  all ship cells hit (or shots exhausted, see option)
- busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset clr is asynchronous and active-low.
- Reset values (clr low): m_at=0, m_tiro=0, status=00, game_over=0, busy=0, FSM=IDLE, all synchronisers/debounce counters=0, shot counter=0.
- Synchroniser: each button passes through a 2-flop synchroniser. The debounce counter counts consecutive samples equal to the target level and resets on any mismatch.
- FSM states: IDLE, DEB_PRESS, CHECK, DEB_REL.
  - IDLE: on synchronised confirm high, go to DEB_PRESS.
  - DEB_PRESS: after DEB_CYCLES consecutive high samples, go to CHECK. On a low sample, return to IDLE with no write.
  - CHECK (one cycle): decode coord_at and register results, then go to DEB_REL.
  - DEB_REL: after DEB_CYCLES consecutive low samples, go to IDLE. Holding the button does not re-fire.
- Latency: outputs update on edge DEB_CYCLES+3, counting edge 0 as the first edge that samples a raw high (2 sync + DEB_CYCLES debounce + 1 CHECK).
- CHECK rules (evaluated in priority order):
  1. Row>4 or column>6: status=11, no matrix change.
  2. m_tiro[idx]=1: status=11 (repeated), no change.
  3. m_po[idx]=1: set m_tiro[idx] and m_at[idx], status=10.
  4. Otherwise: set m_tiro[idx], status=01.
- status holds its value until the next CHECK or a clear.
- game_over is registered. It is 1 when m_po≠0 and (m_at & m_po)==m_po. When m_po=0, game_over stays 0.
- While game_over=1, CHECK produces status=11 and no writes.
- Clear:
  - A debounced button_clear press (DEB_CYCLES stable high) zeroes m_at, m_tiro, status, game_over and the shot counter, and forces the FSM to DEB_REL if it was in DEB_PRESS/CHECK, otherwise IDLE.
  - Clear has priority over a CHECK in the same cycle; no write occurs in that case.
- m_po is sampled only in CHECK. Changing m_po between shots is allowed; game_over is re-evaluated every cycle.
- clr asserted mid-debounce or mid-CHECK: immediate return to reset values; no partial write survives.

Optional Feature:
- SHOT_LIMIT_EN
  - Defined: a shot counter (width $clog2(MAX_SHOTS+1)) increments on each valid non-repeated shot. When it reaches MAX_SHOTS and game_over is not otherwise set, game_over=1 on the following edge; further shots return status=11. Clear resets the counter.
  - Undefined: no counter; shots are unlimited.

Decomposition:
- Shared package pkg_batalha:
  - constants N_LIN=5, N_COL=7, N_CELLS=35
  - status codes ST_IDLE/ST_AGUA/ST_ACERTO/ST_INVAL
  - FSM state enum
  - function for cell index: col*5+(4-row)
- One sub-module, modulo_debounce_botao (2-flop sync + counter, outputs a stable level). Instantiate it twice: once for confirm, once for clear.

Test Plan (DEB_CYCLES=4):
- Reset, m_po bit idx 34 set (row0,col6); coord_at=6'b000_110, press 10 cycles → edge 7: status=10, m_at[34]=1, m_tiro[34]=1.
- Same coordinate pressed again after release → status=11, m_at/m_tiro unchanged.
- coord_at row=1,col=0 (idx 3), m_po[3]=0 → status=01, m_tiro[3]=1, m_at[3]=0.
- Glitch: confirm high for 3 cycles then low → no state change, busy returns 0, status unchanged.
- coord_at row=5 or col=7 → status=11, matrices unchanged.
- m_po has two ship cells; hit both → game_over=1 one edge after second CHECK; clear press → all outputs 0.
- SHOT_LIMIT_EN, MAX_SHOTS=2: two misses → game_over=1; third press → status=11.
- clr low during DEB_PRESS → outputs at reset values, no write after release.
